fetch_stage: RTL and testbench

- Instruction fetch stage, sits directly upstream of decode_stage.
- Owns the PC and issues one 16-bit instruction read at a time to instruction memory; memory latency is variable.
- Holds the fetched instruction, its PC and PC+2 in a one-entry output buffer, handed to decode with a valid/ready handshake.
- Accepts branch redirects from execute, stops fetching after an HLT opcode, and discards responses that are already in flight when a redirect arrives.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/if_buffer.sv | 32 +++
 rtl/fetch_stage.sv | 94 +++++++++
 tb/tb_fetch_stage.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, fetch FSM states,
// the halt opcode and the fetch-to-decode bundle.
package cpu_pkg;

    localparam int ILEN = 16;
    localparam logic [3:0] HLT_OPCODE = 4'hF;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        WAIT   = 2'd1,
        DROP   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [15:0]     pc;
        logic [15:0]     pc_plus2;
    } if_id_t;

endpackage

// File: rtl/if_buffer.sv
// One-entry fetch output register with valid/ready hand-off,
// load from the fetch FSM and flush on redirect.
module if_buffer
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   flush,
    input  logic   ready,
    input  if_id_t payload,
    output logic   valid,
    output if_id_t entry
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            entry <= '0;
        end else begin
            if (flush)
                valid <= 1'b0;
            else if (load)
                valid <= 1'b1;
            else if (ready)
                valid <= 1'b0;
            if (load)
                entry <= payload;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, single-outstanding request FSM,
// redirect/halt handling, feeding decode through if_buffer.
module fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = cpu_pkg::HLT_OPCODE
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_plus2,
    input  logic        id_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        halted
);
    import cpu_pkg::*;

    fetch_state_t state;
    fetch_state_t state_next;
    logic [15:0]  pc;
    logic         issue;
    logic         take;
    if_id_t       payload;
    if_id_t       entry;

    assign issue = !rst && (state == FETCH) && !redirect
                 && (!if_valid || id_ready);
    assign take  = (state == WAIT) && imem_rvalid && !redirect;

    always_ff @(posedge clk) begin
        if (rst)
            state <= FETCH;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            FETCH:  if (issue) state_next = WAIT;
            WAIT: begin
                if (imem_rvalid)
                    state_next = (imem_rdata[15:12] == HLT_OPCODE)
                               ? HALTED : FETCH;
            end
            DROP:   if (imem_rvalid) state_next = FETCH;
            HALTED: state_next = HALTED;
            default: state_next = FETCH;
        endcase
        // A response still in flight must drain before the next request
        if (redirect)
            state_next = ((state == WAIT || state == DROP) && !imem_rvalid)
                       ? DROP : FETCH;
    end

    always_comb begin
        imem_req  = issue;
        imem_addr = pc;
        halted    = (state == HALTED);
    end

    always_ff @(posedge clk) begin
        if (rst)
            pc <= RESET_PC;
        else if (redirect)
            pc <= redirect_pc;
        else if (take)
            pc <= pc + 16'd2;
    end

    assign payload = '{instr: imem_rdata, pc: pc, pc_plus2: pc + 16'd2};

    if_buffer u_buf (
        .clk     (clk),
        .rst     (rst),
        .load    (take),
        .flush   (redirect),
        .ready   (id_ready),
        .payload (payload),
        .valid   (if_valid),
        .entry   (entry)
    );

    assign if_instr    = entry.instr;
    assign if_pc       = entry.pc;
    assign if_pc_plus2 = entry.pc_plus2;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed table, corner
// sequences and randomized traffic against a transaction-level model.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus2;
    logic        id_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halted;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc_plus2 (if_pc_plus2),
        .id_ready    (id_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;

    typedef struct {
        int          due;
        logic [15:0] data;
    } rsp_t;
    rsp_t q[$];
    logic [15:0] mem [logic [15:0]];

    // Model: what decode should see, plus one pending response slot
    logic [15:0] m_pc;
    logic        m_valid;
    logic [15:0] m_instr;
    logic [15:0] m_ipc;
    logic        m_halt;
    logic        m_inflight;
    logic        m_stale;

    logic        s_req;
    logic [15:0] s_addr;
    logic        s_valid;
    logic [15:0] s_instr;
    logic [15:0] s_pc;
    logic [15:0] s_pc2;
    logic        s_halt;

    typedef struct {
        logic        rdy;
        logic        rd;
        logic [15:0] rpc;
        logic        ereq;
        logic [15:0] eaddr;
        logic        evalid;
        logic [15:0] einstr;
        logic [15:0] epc;
        logic        ehalt;
    } vec_t;
    vec_t vt[21];

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got %h expected %h",
                     name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] memword(input logic [15:0] a);
        logic [15:0] w;
        if (!mem.exists(a)) begin
            w = 16'($urandom);
            if ($urandom_range(0, 11) == 0)
                w[15:12] = 4'hF;
            else
                w[15:12] = 4'($urandom_range(0, 14));
            mem[a] = w;
        end
        return mem[a];
    endfunction

    task automatic model_reset();
        m_pc = 16'h0000;
        m_valid = 1'b0;
        m_instr = 16'h0000;
        m_ipc = 16'h0000;
        m_halt = 1'b0;
        m_inflight = 1'b0;
        m_stale = 1'b0;
        q.delete();
    endtask

    task automatic step(input logic rd, input logic [15:0] rpc,
                        input logic rdy);
        logic        rv;
        logic [15:0] rdat;
        logic        ereq;
        redirect = rd;
        redirect_pc = rpc;
        id_ready = rdy;
        rv = 1'b0;
        rdat = 16'h0000;
        if (!rst && q.size() > 0 && q[0].due <= cyc) begin
            rv = 1'b1;
            rdat = q[0].data;
            void'(q.pop_front());
        end
        imem_rvalid = rv;
        imem_rdata = rv ? rdat : 16'($urandom);
        #1;
        s_req = imem_req;
        s_addr = imem_addr;
        s_valid = if_valid;
        s_instr = if_instr;
        s_pc = if_pc;
        s_pc2 = if_pc_plus2;
        s_halt = halted;
        ereq = !rst && !m_halt && !m_inflight && !rd
             && (!m_valid || rdy);
        chk("req", 16'(s_req), 16'(ereq));
        if (ereq) chk("addr", s_addr, m_pc);
        if (!rst) begin
            chk("valid", 16'(s_valid), 16'(m_valid));
            chk("halted", 16'(s_halt), 16'(m_halt));
            if (m_valid) begin
                chk("instr", s_instr, m_instr);
                chk("pc", s_pc, m_ipc);
                chk("pc_plus2", s_pc2, m_ipc + 16'd2);
            end
        end
        if (s_req && !rst)
            q.push_back('{due: cyc + lat, data: memword(s_addr)});
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            if (m_valid && rdy) m_valid = 1'b0;
            if (rv && m_inflight) begin
                m_inflight = 1'b0;
                if (!m_stale && !rd) begin
                    m_valid = 1'b1;
                    m_instr = rdat;
                    m_ipc = m_pc;
                    m_pc = m_pc + 16'd2;
                    if (rdat[15:12] == 4'hF) m_halt = 1'b1;
                end
                m_stale = 1'b0;
            end
            if (rd) begin
                m_pc = rpc;
                m_valid = 1'b0;
                m_halt = 1'b0;
                if (m_inflight) m_stale = 1'b1;
            end
            if (ereq) begin
                m_inflight = 1'b1;
                m_stale = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 16'h0, 1'b1);
        step(1'b0, 16'h0, 1'b1);
        rst = 1'b0;
    endtask

    function automatic vec_t mk(input logic rdy, input logic rd,
                                input logic [15:0] rpc, input logic ereq,
                                input logic [15:0] eaddr,
                                input logic evalid,
                                input logic [15:0] einstr,
                                input logic [15:0] epc,
                                input logic ehalt);
        vec_t v;
        v = '{rdy, rd, rpc, ereq, eaddr, evalid, einstr, epc, ehalt};
        return v;
    endfunction

    initial begin
        logic found;
        logic seen;

        vt[0]  = mk(1, 0, 16'h0, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0);
        vt[1]  = mk(1, 0, 16'h0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
        vt[2]  = mk(1, 0, 16'h0, 1, 16'h0002, 1, 16'h0123, 16'h0000, 0);
        vt[3]  = mk(1, 0, 16'h0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
        for (int i = 4; i < 9; i++)
            vt[i] = mk(0, 0, 16'h0, 0, 16'h0, 1, 16'h1456, 16'h0002, 0);
        vt[9]  = mk(1, 0, 16'h0, 1, 16'h0004, 1, 16'h1456, 16'h0002, 0);
        vt[10] = mk(1, 0, 16'h0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
        vt[11] = mk(1, 0, 16'h0, 1, 16'h0006, 1, 16'h2789, 16'h0004, 0);
        vt[12] = mk(1, 0, 16'h0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
        vt[13] = mk(0, 0, 16'h0, 0, 16'h0000, 1, 16'hF000, 16'h0006, 1);
        vt[14] = mk(1, 0, 16'h0, 0, 16'h0000, 1, 16'hF000, 16'h0006, 1);
        vt[15] = mk(1, 0, 16'h0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1);
        vt[16] = mk(1, 1, 16'h10, 0, 16'h0000, 0, 16'h0000, 16'h0000, 1);
        vt[17] = mk(1, 0, 16'h0, 1, 16'h0010, 0, 16'h0000, 16'h0000, 0);
        vt[18] = mk(1, 0, 16'h0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
        vt[19] = mk(1, 0, 16'h0, 1, 16'h0012, 1, 16'h3ABC, 16'h0010, 0);
        vt[20] = mk(1, 0, 16'h0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0);

        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = 16'h0;
        id_ready = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = 16'h0;
        model_reset();
        @(posedge clk);
        #1;

        // Directed table: fetch, stall, halt, resume
        mem[16'h0000] = 16'h0123;
        mem[16'h0002] = 16'h1456;
        mem[16'h0004] = 16'h2789;
        mem[16'h0006] = 16'hF000;
        mem[16'h0010] = 16'h3ABC;
        mem[16'h0012] = 16'h4DEF;
        lat = 1;
        do_reset();
        chk("rst_valid", 16'(if_valid), 16'h0);
        chk("rst_instr", if_instr, 16'h0);
        chk("rst_pc", if_pc, 16'h0);
        chk("rst_pc2", if_pc_plus2, 16'h0);
        chk("rst_halted", 16'(halted), 16'h0);
        for (int i = 0; i < 21; i++) begin
            step(vt[i].rd, vt[i].rpc, vt[i].rdy);
            chk("t_req", 16'(s_req), 16'(vt[i].ereq));
            if (vt[i].ereq) chk("t_addr", s_addr, vt[i].eaddr);
            chk("t_valid", 16'(s_valid), 16'(vt[i].evalid));
            chk("t_halted", 16'(s_halt), 16'(vt[i].ehalt));
            if (vt[i].evalid) begin
                chk("t_instr", s_instr, vt[i].einstr);
                chk("t_pc", s_pc, vt[i].epc);
                chk("t_pc2", s_pc2, vt[i].epc + 16'd2);
            end
        end

        // Redirect while waiting on a 3-cycle fetch
        mem.delete();
        mem[16'h0000] = 16'h5555;
        mem[16'h0040] = 16'h6666;
        lat = 3;
        do_reset();
        step(1'b0, 16'h0, 1'b1);
        chk("a_first_req", 16'(s_req), 16'h1);
        step(1'b1, 16'h0040, 1'b1);
        found = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b0, 16'h0, 1'b1);
            if (s_valid) seen = 1'b1;
            if (s_req) found = 1'b1;
        end
        chk("a_req_seen", 16'(found), 16'h1);
        chk("a_redir_addr", s_addr, 16'h0040);
        chk("a_late_dropped", 16'(seen), 16'h0);

        // Redirect coinciding with the response
        lat = 1;
        do_reset();
        step(1'b0, 16'h0, 1'b1);
        step(1'b1, 16'h0080, 1'b1);
        step(1'b0, 16'h0, 1'b1);
        chk("b_valid", 16'(s_valid), 16'h0);
        chk("b_req", 16'(s_req), 16'h1);
        chk("b_addr", s_addr, 16'h0080);

        // PC wrap at the top of the address space
        mem.delete();
        mem[16'h0000] = 16'h2222;
        mem[16'hFFFE] = 16'h1111;
        do_reset();
        step(1'b0, 16'h0, 1'b1);
        step(1'b1, 16'hFFFE, 1'b1);
        step(1'b0, 16'h0, 1'b1);
        chk("c_addr_fffe", s_addr, 16'hFFFE);
        step(1'b0, 16'h0, 1'b1);
        step(1'b0, 16'h0, 1'b1);
        chk("c_valid", 16'(s_valid), 16'h1);
        chk("c_pc", s_pc, 16'hFFFE);
        chk("c_pc2_wrap", s_pc2, 16'h0000);
        chk("c_addr_wrap", s_addr, 16'h0000);

        // Randomized traffic
        mem.delete();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            lat = $urandom_range(1, 3);
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 11) == 0, 16'($urandom),
                     $urandom_range(0, 9) < 7);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
